// File: rtl/oled_i2c_responder_pkg.sv
// Shared definitions for the SSD1306-style I2C responder: FSM encoding and control-byte layout.
package oled_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam int CTRL_CO_BIT = 7;
    localparam int CTRL_DC_BIT = 6;

    localparam logic [7:0] CTRL_CMD_STREAM  = 8'h00;
    localparam logic [7:0] CTRL_DATA_STREAM = 8'h40;
    localparam logic [7:0] CTRL_CMD_SINGLE  = 8'h80;
    localparam logic [7:0] CTRL_DATA_SINGLE = 8'hC0;

endpackage

// File: rtl/oled_i2c_responder_if.sv
// Received-byte stream from the responder to the frame-buffer/command sink.
// byte_ready is only looked at in the byte_valid cycle; there is no retry, a refusal becomes a NACK.
interface oled_i2c_responder_if;
    logic [7:0] byte_out;
    logic       byte_is_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_is_data, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_is_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/oled_i2c_responder_line_sync.sv
// Two-flop synchronizer for SCL/SDA with SCL edge and START/STOP detection (3 cycles pad-to-event).
// A sample in which both lines move counts as a data change, so START/STOP need SCL high twice.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl;

    // Idle-high reset values keep the first samples after reset from looking like edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff   <= 2'b11;
            sda_ff   <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[0], scl_i};
            sda_ff   <= {sda_ff[0], sda_i};
            scl_prev <= scl_ff[1];
            sda_prev <= sda_ff[1];
        end
    end

    assign scl       = scl_ff[1];
    assign sda       = sda_ff[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;
endmodule

// File: rtl/oled_i2c_responder.sv
// SSD1306-style I2C target: address match, control-byte decode, payload bytes out; byte_valid 1 cycle after 8th SCL rise.
// Sink refusal NACKs the byte and ignores the rest of the frame; OLED_RD_STATUS_EN adds status-byte reads.
module oled_i2c_responder
    import oled_i2c_pkg::*;
#(
    parameter logic [6:0] ADDR_BASE  = 7'h3C
`ifdef OLED_RD_STATUS_EN
    ,
    parameter logic [7:0] STATUS_VAL = 8'h43
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    input  logic addr_sel,
    output logic sda_oe,
    output logic frame_start,
    output logic frame_end,
    output logic overrun,
    output logic busy,
    oled_i2c_responder_if.master bus
);
`ifdef OLED_RD_STATUS_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d;
    logic       byte_done, byte_done_d;
    logic       ack_go, ack_go_d;
    logic       co, co_d, dc, dc_d;
    logic       sda_oe_d, busy_d, frame_start_d, frame_end_d, overrun_d;
    logic       byte_valid;
    logic [6:0] match_addr;
`ifdef OLED_RD_STATUS_EN
    logic [7:0] tx_sh, tx_sh_d;
`endif

    assign match_addr = ADDR_BASE | {6'b0, addr_sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            byte_done   <= 1'b0;
            ack_go      <= 1'b0;
            co          <= 1'b0;
            dc          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            overrun     <= 1'b0;
`ifdef OLED_RD_STATUS_EN
            tx_sh       <= 8'd0;
`endif
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            shreg       <= shreg_d;
            byte_done   <= byte_done_d;
            ack_go      <= ack_go_d;
            co          <= co_d;
            dc          <= dc_d;
            sda_oe      <= sda_oe_d;
            busy        <= busy_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            overrun     <= overrun_d;
`ifdef OLED_RD_STATUS_EN
            tx_sh       <= tx_sh_d;
`endif
        end
    end

    always_comb begin
        state_d       = state;
        bit_cnt_d     = bit_cnt;
        shreg_d       = shreg;
        byte_done_d   = 1'b0;
        ack_go_d      = ack_go;
        co_d          = co;
        dc_d          = dc;
        sda_oe_d      = sda_oe;
        busy_d        = busy;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        overrun_d     = 1'b0;
        byte_valid    = 1'b0;
`ifdef OLED_RD_STATUS_EN
        tx_sh_d       = tx_sh;
`endif
        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            ack_go_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            sda_oe_d    = 1'b0;
            ack_go_d    = 1'b0;
            busy_d      = 1'b0;
            frame_end_d = busy;
        end else begin
            case (state)
                ST_ADDR, ST_CTRL, ST_RX: begin
                    if (scl_rise) begin
                        shreg_d     = {shreg[6:0], sda};
                        bit_cnt_d   = bit_cnt + 3'd1;
                        byte_done_d = (bit_cnt == 3'd7);
                    end
                    if (byte_done) begin
                        if (state == ST_ADDR) begin
                            if (shreg[7:1] == match_addr && (!shreg[0] || RD_EN))
                                ack_go_d = 1'b1;
                            else
                                state_d = ST_WAIT_STOP;
                        end else if (state == ST_CTRL) begin
                            co_d     = shreg[CTRL_CO_BIT];
                            dc_d     = shreg[CTRL_DC_BIT];
                            ack_go_d = 1'b1;
                        end else begin
                            byte_valid = 1'b1;
                            if (bus.byte_ready) begin
                                ack_go_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                                state_d   = ST_WAIT_STOP;
                            end
                        end
                    end
                    // ACK is driven only once SCL has gone low after the 8th bit.
                    if (scl_fall && ack_go) begin
                        ack_go_d = 1'b0;
                        sda_oe_d = 1'b1;
                        if (state == ST_ADDR) begin
                            state_d       = ST_ADDR_ACK;
                            frame_start_d = ~shreg[0];
                            busy_d        = 1'b1;
                        end else if (state == ST_CTRL) begin
                            state_d = ST_CTRL_ACK;
                        end else begin
                            state_d = ST_RX_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_CTRL;
`ifdef OLED_RD_STATUS_EN
                        if (shreg[0]) begin
                            state_d  = ST_TX;
                            sda_oe_d = ~STATUS_VAL[7];
                            tx_sh_d  = {STATUS_VAL[6:0], 1'b0};
                        end
`endif
                    end
                end
                ST_CTRL_ACK, ST_RX_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = (state == ST_RX_ACK && !co) ? ST_RX : (state == ST_RX_ACK ? ST_CTRL : ST_RX);
                    end
                end
`ifdef OLED_RD_STATUS_EN
                ST_TX: begin
                    if (scl_rise) bit_cnt_d = bit_cnt + 3'd1;
                    // A fall with the count wrapped back to 0 follows the 8th bit.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_sh[7];
                            tx_sh_d  = {tx_sh[6:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) shreg_d = {shreg[6:0], sda};
                    if (scl_fall) begin
                        if (!shreg[0]) begin
                            state_d   = ST_TX;
                            bit_cnt_d = 3'd0;
                            sda_oe_d  = ~STATUS_VAL[7];
                            tx_sh_d   = {STATUS_VAL[6:0], 1'b0};
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.byte_out     = shreg;
    assign bus.byte_is_data = dc;
    assign bus.byte_valid   = byte_valid;
endmodule

// File: tb/tb_oled_i2c_responder.sv
// Directed bench for oled_i2c_responder: bit-banged I2C master, byte-stream monitor, vector table plus corner sequences.
module tb_oled_i2c_responder;
    import oled_i2c_pkg::*;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic master_sda = 1'b1;
    logic addr_sel = 1'b0;
    logic sda_oe, frame_start, frame_end, overrun, busy;
    logic sda_line;

    oled_i2c_responder_if bus ();

    oled_i2c_responder dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl),
        .sda_i       (sda_line),
        .addr_sel    (addr_sel),
        .sda_oe      (sda_oe),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .overrun     (overrun),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    assign sda_line = master_sda & ~sda_oe;

    logic       drop_en = 1'b0;
    int         drop_idx = 0;
    int         vcount = 0, fs_cnt = 0, fe_cnt = 0, ov_cnt = 0, bz_cnt = 0;
    logic [8:0] rx_q[$];
    assign bus.byte_ready = !(drop_en && vcount == drop_idx);

    always @(posedge clk) begin
        if (bus.byte_valid) begin
            rx_q.push_back({bus.byte_is_data, bus.byte_out});
            vcount <= vcount + 1;
        end
        if (frame_start) fs_cnt <= fs_cnt + 1;
        if (frame_end)   fe_cnt <= fe_cnt + 1;
        if (overrun)     ov_cnt <= ov_cnt + 1;
        if (busy)        bz_cnt <= bz_cnt + 1;
    end

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int base_q, fs0, fe0, ov0, bz0;
    task automatic snap();
        base_q = rx_q.size(); fs0 = fs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; bz0 = bz_cnt;
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wait_q(); master_sda = b;
        wait_q(); scl = 1'b1;
        wait_q(); s = sda_line;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_start();
        master_sda = 1'b1; scl = 1'b1; wait_q();
        master_sda = 1'b0; wait_q();
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        scl = 1'b0; wait_q();
        master_sda = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        master_sda = 1'b1; wait_q();
    endtask

    logic [15:0] ack_bits;
    task automatic wr_byte(input logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack_bits = {ack_bits[14:0], ~s};
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~mack, s);
    endtask

    logic [7:0] tx_bytes[$];
    task automatic do_write(input logic [6:0] a);
        ack_bits = '0;
        i2c_start();
        wr_byte({a, 1'b0});
        foreach (tx_bytes[i]) wr_byte(tx_bytes[i]);
        i2c_stop();
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic       sel;
        logic [6:0] addr;
        logic [7:0] ctrl;
        logic [7:0] dat;
        logic       exp_ack;
        logic       exp_is_data;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r0, r1;
        int errs;

        vecs[0] = '{1'b0, 7'h3C, CTRL_CMD_STREAM,  8'hAE, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 7'h3C, CTRL_DATA_STREAM, 8'h5A, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 7'h3C, CTRL_CMD_STREAM,  8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 7'h3D, CTRL_DATA_SINGLE, 8'h12, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 7'h3D, CTRL_DATA_STREAM, 8'h13, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 7'h3C, CTRL_CMD_SINGLE,  8'hF0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 7'h3C, 8'h3F,            8'h77, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 7'h3C, 8'h7F,            8'h88, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {sda_oe, bus.byte_valid, frame_start, frame_end, overrun, busy}, 6'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_outputs", {sda_oe, bus.byte_valid, frame_start, frame_end, overrun, busy}, 6'b0);

        for (int i = 0; i < 8; i++) begin
            addr_sel = vecs[i].sel;
            snap();
            tx_bytes = '{vecs[i].ctrl, vecs[i].dat};
            do_write(vecs[i].addr);
            check($sformatf("v%0d_acks", i), ack_bits[2:0], vecs[i].exp_ack ? 3'b111 : 3'b000);
            check($sformatf("v%0d_nvalid", i), rx_q.size() - base_q, vecs[i].exp_ack ? 1 : 0);
            check($sformatf("v%0d_frame_start", i), fs_cnt - fs0, vecs[i].exp_ack ? 1 : 0);
            check($sformatf("v%0d_frame_end", i), fe_cnt - fe0, vecs[i].exp_ack ? 1 : 0);
            check($sformatf("v%0d_busy_seen", i), (bz_cnt - bz0) > 0, vecs[i].exp_ack);
            if (vecs[i].exp_ack && rx_q.size() > base_q)
                check($sformatf("v%0d_byte", i), rx_q[base_q], {vecs[i].exp_is_data, vecs[i].dat});
        end
        addr_sel = 1'b0;

        // Command stream of three bytes.
        snap();
        tx_bytes = '{8'h00, 8'hAE, 8'hD5, 8'h80};
        do_write(7'h3C);
        check("cmd3_acks", ack_bits[4:0], 5'b11111);
        check("cmd3_nvalid", rx_q.size() - base_q, 3);
        if (rx_q.size() - base_q == 3)
            check("cmd3_bytes", {rx_q[base_q], rx_q[base_q+1], rx_q[base_q+2]}, {9'h0AE, 9'h0D5, 9'h080});
        check("cmd3_frames", {fs_cnt - fs0, fe_cnt - fe0}, {32'd1, 32'd1});

        // Long GDDRAM data stream.
        snap();
        tx_bytes = '{8'h40};
        for (int i = 0; i < 264; i++) tx_bytes.push_back(8'(i * 7 + 3));
        do_write(7'h3C);
        check("stream_nvalid", rx_q.size() - base_q, 264);
        errs = 0;
        for (int i = 0; i < 264; i++)
            if (base_q + i >= rx_q.size() || rx_q[base_q+i] !== {1'b1, 8'(i * 7 + 3)}) errs++;
        check("stream_order", errs, 0);

        // Co=1 single command then single data byte.
        snap();
        tx_bytes = '{8'h80, 8'hAF, 8'hC0, 8'h55};
        do_write(7'h3C);
        check("single_acks", ack_bits[4:0], 5'b11111);
        check("single_nvalid", rx_q.size() - base_q, 2);
        if (rx_q.size() - base_q == 2)
            check("single_bytes", {rx_q[base_q], rx_q[base_q+1]}, {9'h0AF, 9'h155});

        // Sink refuses the second payload byte.
        snap();
        drop_en = 1'b1; drop_idx = vcount + 1;
        tx_bytes = '{8'h40, 8'h11, 8'h22, 8'h33, 8'h44};
        do_write(7'h3C);
        drop_en = 1'b0;
        check("ovr_acks", ack_bits[5:0], 6'b111000);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_nvalid", rx_q.size() - base_q, 2);
        check("ovr_frame_end", fe_cnt - fe0, 1);

        // Status read.
        snap();
        ack_bits = '0;
        i2c_start();
        wr_byte({7'h3C, 1'b1});
        rd_byte(1'b1, r0);
        rd_byte(1'b0, r1);
        i2c_stop();
        repeat (4) @(negedge clk);
`ifdef OLED_RD_STATUS_EN
        check("rd_addr_ack", ack_bits[0], 1'b1);
        check("rd_bytes", {r0, r1}, 16'h4343);
        check("rd_frames", {fs_cnt - fs0, fe_cnt - fe0}, {32'd0, 32'd1});
`else
        check("rd_addr_ack", ack_bits[0], 1'b0);
        check("rd_bytes", {r0, r1}, 16'hFFFF);
        check("rd_frames", {fs_cnt - fs0, fe_cnt - fe0}, {32'd0, 32'd0});
`endif

        // Reset asserted while the responder holds the RX ACK.
        begin
            logic s;
            ack_bits = '0;
            i2c_start();
            wr_byte({7'h3C, 1'b0});
            wr_byte(8'h40);
            for (int i = 7; i >= 0; i--) clk_bit(r0[i], s);
            wait_q(); master_sda = 1'b1;
            wait_q(); scl = 1'b1;
            wait_q();
            check("rxack_held", sda_oe, 1'b1);
            rst = 1'b1;
            #1;
            check("rxack_async_release", sda_oe, 1'b0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check("rxack_reset_busy", busy, 1'b0);
            i2c_stop();
        end
        snap();
        tx_bytes = '{8'h40, 8'h99};
        do_write(7'h3C);
        check("after_reset_acks", ack_bits[2:0], 3'b111);
        check("after_reset_nvalid", rx_q.size() - base_q, 1);
        if (rx_q.size() > base_q) check("after_reset_byte", rx_q[base_q], 9'h199);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
